// File: rtl/hex_display_writer.sv
// Avalon-MM master that writes one 7-segment word per digit to a bank of PIO slaves,
// optionally reading each back, and reports done / sticky error.
module hex_display_writer #(
    parameter int          NUM_DIGITS  = 6,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ADDR_STRIDE = 16,
    parameter bit          VERIFY      = 1'b1,
    parameter int          TIMEOUT     = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [31:0]             avm_address,
    output logic                    avm_write,
    output logic                    avm_read,
    output logic [31:0]             avm_writedata,
    output logic [3:0]              avm_byteenable,
    input  logic [31:0]             avm_readdata,
    input  logic                    avm_waitrequest
);

    // state  | meaning
    // IDLE   | waiting for start
    // WRITE  | write request for digit idx on the bus
    // READ   | readback request for digit idx on the bus
    // NEXT   | advance to next digit or finish
    // DONE   | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_NEXT,
        S_DONE
    } state_t;

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t                  state, state_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic [4*NUM_DIGITS-1:0] val_q, val_nxt;
    logic [NUM_DIGITS-1:0]   blank_q, blank_nxt;
    logic                    error_q, error_nxt;
    logic [TW-1:0]           tcnt, tcnt_nxt;
    logic                    write_q, read_q;
    logic [31:0]             addr_q, addr_nxt;
    logic [6:0]              seg_q, seg_nxt;
    logic                    unused_rdata;

    function automatic logic [6:0] encode(input logic [3:0] nib, input logic blk);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return blk ? 7'h7F : s;
    endfunction

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        val_nxt   = val_q;
        blank_nxt = blank_q;
        error_nxt = error_q;
        tcnt_nxt  = tcnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    val_nxt   = value;
                    blank_nxt = blank;
                    error_nxt = 1'b0;
                    idx_nxt   = '0;
                    tcnt_nxt  = '0;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE, S_READ: begin
                if (avm_waitrequest) begin
                    // abort on the TIMEOUT-th consecutive stalled cycle
                    if (tcnt == TW'(TIMEOUT - 1)) begin
                        error_nxt = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        tcnt_nxt = tcnt + TW'(1);
                    end
                end else begin
                    tcnt_nxt = '0;
                    if (state == S_WRITE) begin
                        state_nxt = VERIFY ? S_READ : S_NEXT;
                    end else begin
                        if (avm_readdata[6:0] != seg_q) error_nxt = 1'b1;
                        state_nxt = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                tcnt_nxt = '0;
                if (idx == IW'(NUM_DIGITS - 1)) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt   = idx + IW'(1);
                    state_nxt = S_WRITE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        addr_nxt = BASE_ADDR + 32'(idx_nxt) * 32'(ADDR_STRIDE);
        seg_nxt  = encode(val_nxt[4*idx_nxt +: 4], blank_nxt[idx_nxt]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            val_q   <= '0;
            blank_q <= '0;
            error_q <= 1'b0;
            tcnt    <= '0;
            write_q <= 1'b0;
            read_q  <= 1'b0;
            addr_q  <= BASE_ADDR;
            seg_q   <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            val_q   <= val_nxt;
            blank_q <= blank_nxt;
            error_q <= error_nxt;
            tcnt    <= tcnt_nxt;
            write_q <= (state_nxt == S_WRITE);
            read_q  <= (state_nxt == S_READ);
            // address/data only move when a new write is launched; READ reuses them
            if (state_nxt == S_WRITE) begin
                addr_q <= addr_nxt;
                seg_q  <= seg_nxt;
            end
        end
    end

    assign unused_rdata   = ^avm_readdata[31:7];
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);
    assign error          = error_q;
    assign avm_address    = addr_q;
    assign avm_write      = write_q;
    assign avm_read       = read_q;
    assign avm_writedata  = {25'b0, seg_q};
    assign avm_byteenable = 4'hF;

endmodule
